spram_bwe_init: RTL and testbench

- Parametrised single-port RAM: the successor to the vendor-macro wrapper, with a portable behavioural memory array.
- Adds per-byte write enables, selectable read latency (1 or 2) and three write modes.
- Adds a hardware init-sweep FSM that fills every word with a constant after reset or on request. Cache tag/valid arrays use it to drop software invalidation loops.

---
 rtl/spram_bwe_init.sv | 140 ++++++++++++++
 tb/tb_spram_bwe_init.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/spram_bwe_init.sv
// Single-port RAM with per-byte write enables, 1- or 2-cycle read latency,
// selectable write mode and a hardware sweep that fills every word with INIT_VALUE.
module spram_bwe_init #(
  parameter int                    DATA_WIDTH    = 32,
  parameter int                    BYTE_WIDTH    = 8,
  parameter int                    DEPTH         = 128,
  parameter int                    LATENCY       = 1,
  parameter string                 WRITE_MODE    = "write_first",
  parameter int                    INIT_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE    = '0,
  localparam int                   NB            = DATA_WIDTH / BYTE_WIDTH,
  localparam int                   AW            = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [NB-1:0]         we,
  input  logic [AW-1:0]         addr,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  init,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  busy
);

  localparam logic       S_IDLE  = 1'b0;
  localparam logic       S_SWEEP = 1'b1;
  localparam logic [1:0] M_WF    = 2'd0;
  localparam logic [1:0] M_RF    = 2'd1;
  localparam logic [1:0] M_NC    = 2'd2;
  localparam logic [1:0] MODE    = (WRITE_MODE == "read_first") ? M_RF :
                                   (WRITE_MODE == "no_change")  ? M_NC : M_WF;

  generate
    if (LATENCY != 1 && LATENCY != 2) begin : g_bad_latency
      $error("spram_bwe_init: LATENCY must be 1 or 2");
    end
    if (WRITE_MODE != "write_first" && WRITE_MODE != "read_first" &&
        WRITE_MODE != "no_change") begin : g_bad_mode
      $error("spram_bwe_init: WRITE_MODE must be write_first, read_first or no_change");
    end
    if ((DATA_WIDTH % BYTE_WIDTH) != 0) begin : g_bad_width
      $error("spram_bwe_init: DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end
  endgenerate

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic                  r_state;
  logic [AW-1:0]         r_cnt;
  logic [DATA_WIDTH-1:0] r_r1;
  logic                  w_busy;
  logic                  w_acc;
  logic                  w_wr;
  logic [DATA_WIDTH-1:0] w_old;
  logic [DATA_WIDTH-1:0] w_merged;

  assign w_busy = (r_state == S_SWEEP);
  assign busy   = w_busy;
  assign w_acc  = en && !w_busy;
  assign w_wr   = w_acc && (|we);
  assign w_old  = r_mem[addr];

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_lane
      assign w_merged[gi*BYTE_WIDTH +: BYTE_WIDTH] =
        we[gi] ? din[gi*BYTE_WIDTH +: BYTE_WIDTH] : w_old[gi*BYTE_WIDTH +: BYTE_WIDTH];
    end
  endgenerate

  // Array is never reset; nothing is written while rst_n is low.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (w_busy) begin
        r_mem[r_cnt] <= INIT_VALUE;
      end else if (w_wr) begin
        for (int i = 0; i < NB; i++) begin
          if (we[i]) begin
            r_mem[addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= din[i*BYTE_WIDTH +: BYTE_WIDTH];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= (INIT_ON_RESET != 0) ? S_SWEEP : S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (init) begin
            r_state <= S_SWEEP;
            r_cnt   <= '0;
          end
        end
        default: begin
          r_cnt <= r_cnt + AW'(1);
          if (r_cnt == AW'(DEPTH - 1)) begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_r1 <= '0;
    end else if (w_acc) begin
      if (!(|we) || MODE == M_RF) begin
        r_r1 <= w_old;
      end else if (MODE == M_WF) begin
        r_r1 <= w_merged;
      end
    end
  end

  generate
    if (LATENCY == 2) begin : g_lat2
      logic                  r_vld1;
      logic [DATA_WIDTH-1:0] r_r2;
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_vld1 <= 1'b0;
          r_r2   <= '0;
        end else begin
          r_vld1 <= w_acc;
          if (r_vld1) begin
            r_r2 <= r_r1;
          end
        end
      end
      assign dout = r_r2;
    end else begin : g_lat1
      assign dout = r_r1;
    end
  endgenerate

endmodule

// File: tb/tb_spram_bwe_init.sv
// Drives three RAM variants (write_first/L1, read_first/L2, no_change/L1) with one
// stimulus stream and checks dout/busy against an array-based model through a scoreboard.
module tb_spram_bwe_init;
  localparam int          DEPTH = 16;
  localparam int          NI    = 3;
  localparam logic [31:0] INITV = 32'hDEAD_BEEF;

  logic          clk = 1'b0;
  logic          rst_n, en, init;
  logic [3:0]    we, addr;
  logic [31:0]   din;
  logic [31:0]   douts [NI];
  logic [NI-1:0] busys;

  always #5 clk = ~clk;

  spram_bwe_init #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .DEPTH(DEPTH), .LATENCY(1),
                   .WRITE_MODE("write_first"), .INIT_ON_RESET(1), .INIT_VALUE(INITV))
    u_wf (.clk(clk), .rst_n(rst_n), .en(en), .we(we), .addr(addr), .din(din),
          .init(init), .dout(douts[0]), .busy(busys[0]));
  spram_bwe_init #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .DEPTH(DEPTH), .LATENCY(2),
                   .WRITE_MODE("read_first"), .INIT_ON_RESET(1), .INIT_VALUE(INITV))
    u_rf (.clk(clk), .rst_n(rst_n), .en(en), .we(we), .addr(addr), .din(din),
          .init(init), .dout(douts[1]), .busy(busys[1]));
  spram_bwe_init #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .DEPTH(DEPTH), .LATENCY(1),
                   .WRITE_MODE("no_change"), .INIT_ON_RESET(1), .INIT_VALUE(INITV))
    u_nc (.clk(clk), .rst_n(rst_n), .en(en), .we(we), .addr(addr), .din(din),
          .init(init), .dout(douts[2]), .busy(busys[2]));

  typedef struct {
    int          k;
    int          due;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_r1 [NI];
  logic [31:0] exp_dout [NI];
  int          sweep_left = 0;
  int          edge_no = 0;
  int          last_chk = 0;
  bit          exp_busy = 1'b0;
  int          n_tests = 0;
  int          n_fail = 0;

  function automatic int lat_of(input int k);
    return (k == 1) ? 2 : 1;
  endfunction

  // Model for the edge that follows: RAM as a plain array, sweep as a count of words left.
  task automatic cyc(input bit r, input bit e, input logic [3:0] w, input logic [3:0] a,
                     input logic [31:0] d, input bit i);
    logic [31:0] old, nw;
    bit          was_idle;
    exp_t        it;
    rst_n = r; en = e; we = w; addr = a; din = d; init = i;
    edge_no++;
    if (!r) begin
      sweep_left = DEPTH;
      sb.delete();
      for (int k = 0; k < NI; k++) begin
        m_r1[k] = 32'h0;
        it.k = k; it.due = edge_no; it.val = 32'h0;
        sb.push_back(it);
      end
    end else begin
      was_idle = (sweep_left == 0);
      if (!was_idle) begin
        m_mem[DEPTH - sweep_left] = INITV;
        sweep_left--;
      end else if (e) begin
        old = m_mem[a];
        for (int b = 0; b < 4; b++) nw[8*b +: 8] = w[b] ? d[8*b +: 8] : old[8*b +: 8];
        for (int k = 0; k < NI; k++) begin
          if (w == 4'h0)   m_r1[k] = old;
          else if (k == 0) m_r1[k] = nw;
          else if (k == 1) m_r1[k] = old;
          it.k = k; it.due = edge_no + lat_of(k) - 1; it.val = m_r1[k];
          sb.push_back(it);
        end
        m_mem[a] = nw;
        $display("[TB] edge %0d access addr=%0d we=%h din=%h old=%h", edge_no, a, w, d, old);
      end
      if (was_idle && i) sweep_left = DEPTH;
    end
    exp_busy = (sweep_left > 0);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (edge_no > last_chk) begin
        last_chk = edge_no;
        for (int j = 0; j < sb.size(); ) begin
          if (sb[j].due == edge_no) begin
            exp_dout[sb[j].k] = sb[j].val;
            sb.delete(j);
          end else begin
            if (sb[j].due < edge_no) begin
              n_tests++; n_fail++;
              $display("FAIL sb_stale inst%0d: due edge %0d still pending at edge %0d",
                       sb[j].k, sb[j].due, edge_no);
              sb.delete(j);
            end else begin
              j++;
            end
          end
        end
        for (int k = 0; k < NI; k++) begin
          n_tests++;
          if (douts[k] !== exp_dout[k]) begin
            n_fail++;
            $display("FAIL dout inst%0d edge %0d: got %h expected %h",
                     k, edge_no, douts[k], exp_dout[k]);
          end
        end
        n_tests++;
        if (busys !== {NI{exp_busy}}) begin
          n_fail++;
          $display("FAIL busy edge %0d: got %b expected %b", edge_no, busys, {NI{exp_busy}});
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; we = 4'h0; addr = 4'h0; din = 32'h0; init = 1'b0;
    for (int k = 0; k < NI; k++) exp_dout[k] = 32'hx;

    // Reset-time sweep, then read back every word.
    repeat (3) cyc(1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0);
    repeat (18) cyc(1'b1, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0);
    for (int a = 0; a < DEPTH; a++) cyc(1'b1, 1'b1, 4'h0, 4'(a), 32'h0, 1'b0);

    // Byte-lane merge.
    cyc(1'b1, 1'b1, 4'hF, 4'd5, 32'h1122_3344, 1'b0);
    cyc(1'b1, 1'b1, 4'b0101, 4'd5, 32'hAABB_CCDD, 1'b0);
    cyc(1'b1, 1'b1, 4'h0, 4'd5, 32'h0, 1'b0);

    // Write-mode read data.
    cyc(1'b1, 1'b1, 4'hF, 4'd3, 32'h0, 1'b0);
    cyc(1'b1, 1'b1, 4'h0, 4'd9, 32'h0, 1'b0);
    cyc(1'b1, 1'b1, 4'hF, 4'd3, 32'h1234_5678, 1'b0);
    cyc(1'b1, 1'b0, 4'h0, 4'd0, 32'h0, 1'b0);

    // Back-to-back reads, then hold.
    for (int a = 0; a < 3; a++) cyc(1'b1, 1'b1, 4'hF, 4'(a), 32'hA000_0000 + 32'(a), 1'b0);
    for (int a = 0; a < 3; a++) cyc(1'b1, 1'b1, 4'h0, 4'(a), 32'h0, 1'b0);
    repeat (4) cyc(1'b1, 1'b0, 4'h0, 4'd0, 32'h0, 1'b0);

    // init together with a write; writes during the sweep are dropped.
    cyc(1'b1, 1'b1, 4'hF, 4'd7, 32'h0000_CAFE, 1'b1);
    repeat (16) cyc(1'b1, 1'b1, 4'hF, 4'd9, 32'h5555_5555, 1'b0);
    cyc(1'b1, 1'b1, 4'h0, 4'd7, 32'h0, 1'b0);
    cyc(1'b1, 1'b1, 4'h0, 4'd9, 32'h0, 1'b0);

    // Reset six cycles into a sweep restarts it.
    cyc(1'b1, 1'b0, 4'h0, 4'd0, 32'h0, 1'b1);
    repeat (6) cyc(1'b1, 1'b0, 4'h0, 4'd0, 32'h0, 1'b0);
    cyc(1'b0, 1'b0, 4'h0, 4'd0, 32'h0, 1'b0);
    repeat (17) cyc(1'b1, 1'b1, 4'h0, 4'($urandom), 32'h0, 1'b0);

    // Random traffic with occasional init and reset.
    for (int n = 0; n < 300; n++) begin
      cyc(($urandom_range(0, 149) != 0), ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom),
          4'($urandom), $urandom, ($urandom_range(0, 39) == 0));
    end
    repeat (4) cyc(1'b1, 1'b0, 4'h0, 4'd0, 32'h0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached at edge %0d", edge_no);
    $fatal(1, "timeout");
  end
endmodule
